// File: rtl/pattern_detector.sv
// Runtime-programmable serial bit-pattern detector: compares the newest accepted
// bits against a loadable pattern, flags matches for one cycle and counts them.
module pattern_detector #(
  parameter  int unsigned MAX_LEN   = 8,
  parameter  int unsigned CNT_WIDTH = 8,
  localparam int unsigned LW        = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 load,
  input  logic [MAX_LEN-1:0]   pattern,
  input  logic [LW-1:0]        pat_len,
  input  logic                 overlap_in,
  input  logic                 enable,
  input  logic                 serial_in,
  input  logic                 count_clear,
  output logic                 match,
  output logic [CNT_WIDTH-1:0] match_count,
  output logic                 armed
);

  // One extra bit so fill+1 and length comparisons never wrap.
  localparam int unsigned FW      = LW + 1;
  localparam int unsigned RST_LEN = (MAX_LEN < 4) ? MAX_LEN : 4;
  localparam logic [MAX_LEN-1:0]   RST_PAT = MAX_LEN'(4'b1101);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [MAX_LEN-1:0]   pat_r;
  logic [LW-1:0]        len_r;
  logic                 ovl_r;
  logic [MAX_LEN-1:0]   hist_q, hist_d;
  logic [LW-1:0]        fill_q, fill_d;
  logic                 match_d;
  logic                 armed_d;
  logic [CNT_WIDTH-1:0] count_d;

  logic [MAX_LEN-1:0]   hist_shift;
  logic [MAX_LEN-1:0]   len_mask;
  logic [FW-1:0]        fill_inc;
  logic [LW-1:0]        load_len;
  logic                 hit;

  // Datapath helpers: shifted history, length mask, saturating fill, clamped length.
  always_comb begin
    hist_shift = MAX_LEN'({hist_q, serial_in});
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (FW'(i) < FW'(len_r));
    end
    fill_inc = (FW'(fill_q) < FW'(MAX_LEN)) ? (FW'(fill_q) + FW'(1)) : FW'(MAX_LEN);
    load_len = (FW'(pat_len) > FW'(MAX_LEN)) ? LW'(MAX_LEN) : pat_len;
    hit      = (state_q != IDLE) && (len_r != '0) &&
               ((FW'(fill_q) + FW'(1)) >= FW'(len_r)) &&
               ((hist_shift & len_mask) == (pat_r & len_mask));
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= FILL;
      pat_r       <= RST_PAT;
      len_r       <= LW'(RST_LEN);
      ovl_r       <= 1'b1;
      hist_q      <= '0;
      fill_q      <= '0;
      match       <= 1'b0;
      armed       <= 1'b0;
      match_count <= '0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      match       <= match_d;
      armed       <= armed_d;
      match_count <= count_d;
      if (load) begin
        pat_r <= pattern;
        len_r <= load_len;
        ovl_r <= overlap_in;
      end
    end
  end

  // Next-state, history, fill, match and counter logic.
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    count_d = match_count;

    if (load) begin
      hist_d  = '0;
      fill_d  = '0;
      state_d = (pat_len == '0) ? IDLE : FILL;
    end else if (enable) begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        FILL, ARMED: begin
          hist_d = hist_shift;
          if (hit) begin
            match_d = 1'b1;
            if (!ovl_r) begin
              // Non-overlapping: discard history so the next match starts fresh.
              fill_d  = '0;
              state_d = FILL;
            end else begin
              fill_d  = LW'(fill_inc);
              state_d = ARMED;
            end
          end else begin
            fill_d  = LW'(fill_inc);
            state_d = ((fill_inc + FW'(1)) >= FW'(len_r)) ? ARMED : FILL;
          end
        end
        default: begin
          state_d = FILL;
          hist_d  = '0;
          fill_d  = '0;
        end
      endcase
    end

    armed_d = (state_d == ARMED);

    if (count_clear) begin
      count_d = '0;
    end else if (match_d && (match_count != CNT_MAX)) begin
      count_d = match_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pattern_detector.sv
// Directed bench for pattern_detector: a default-width instance and a 2-bit
// counter instance share all inputs.
module tb_pattern_detector;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       load;
  logic [7:0] pattern;
  logic [3:0] pat_len;
  logic       overlap_in;
  logic       enable;
  logic       serial_in;
  logic       count_clear;

  logic       match8, armed8;
  logic [7:0] count8;
  logic       match2, armed2;
  logic [1:0] count2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pattern_detector #(.MAX_LEN(8), .CNT_WIDTH(8)) dut8 (
    .clk(clk), .n_rst(n_rst), .load(load), .pattern(pattern), .pat_len(pat_len),
    .overlap_in(overlap_in), .enable(enable), .serial_in(serial_in),
    .count_clear(count_clear), .match(match8), .match_count(count8), .armed(armed8)
  );

  pattern_detector #(.MAX_LEN(8), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .load(load), .pattern(pattern), .pat_len(pat_len),
    .overlap_in(overlap_in), .enable(enable), .serial_in(serial_in),
    .count_clear(count_clear), .match(match2), .match_count(count2), .armed(armed2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic b);
    enable    = en;
    serial_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] p, input logic [3:0] l, input logic o);
    load = 1'b1; pattern = p; pat_len = l; overlap_in = o;
    enable = 1'b1; serial_in = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0; enable = 1'b0;
  endtask

  task automatic clear_counts();
    count_clear = 1'b1; enable = 1'b0;
    @(posedge clk);
    #1;
    count_clear = 1'b0;
  endtask

  // Sends n bits MSB-first from bits; exp_m holds the expected match after each bit.
  task automatic run(input string tag, input int n, input logic [15:0] bits,
                     input logic [15:0] exp_m);
    logic [15:0] b, e;
    b = bits;
    e = exp_m;
    for (int i = 0; i < n; i++) begin
      step(1'b1, b[n-1-i]);
      chk($sformatf("%s_m%0d", tag, i + 1), 32'(match8), 32'(e[n-1-i]));
    end
  endtask

  initial begin
    n_rst = 1'b0; load = 1'b0; pattern = '0; pat_len = '0; overlap_in = 1'b0;
    enable = 1'b0; serial_in = 1'b0; count_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_match", 32'(match8), 0);
    chk("rst_count", 32'(count8), 0);
    chk("rst_armed", 32'(armed8), 0);
    chk("rst_armed2", 32'(armed2), 0);
    n_rst = 1'b1;

    // Default overlapping 1101 detector on 1101101.
    run("def", 7, 16'b1101101, 16'b0001001);
    chk("def_count", 32'(count8), 2);
    clear_counts();
    chk("clr_count", 32'(count8), 0);

    // Pattern 11, overlapping then non-overlapping.
    do_load(8'b11, 4'd2, 1'b1);
    chk("ld11_armed", 32'(armed8), 0);
    run("ov11", 4, 16'b1111, 16'b0111);
    chk("ov11_count", 32'(count8), 3);
    clear_counts();
    do_load(8'b11, 4'd2, 1'b0);
    run("no11", 4, 16'b1111, 16'b0101);
    chk("no11_count", 32'(count8), 2);
    clear_counts();

    // 1101 with enable low for 3 cycles after each bit; gap bits must be ignored.
    do_load(8'b1101, 4'd4, 1'b1);
    begin
      logic [3:0] gb;
      gb = 4'b1101;
      for (int i = 0; i < 4; i++) begin
        step(1'b1, gb[3-i]);
        chk($sformatf("gap_acc%0d", i + 1), 32'(match8), (i == 3) ? 1 : 0);
        for (int g = 0; g < 3; g++) begin
          step(1'b0, 1'b1);
          chk($sformatf("gap_idle%0d_%0d", i + 1, g), 32'(match8), 0);
        end
      end
    end
    chk("gap_count", 32'(count8), 1);
    clear_counts();

    // Single-bit pattern: match every cycle, 2-bit counter saturates.
    do_load(8'b1, 4'd1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1);
      chk($sformatf("sat_m%0d", i + 1), 32'(match2), 1);
    end
    chk("sat_count2", 32'(count2), 3);
    chk("sat_count8", 32'(count8), 10);
    count_clear = 1'b1;
    step(1'b1, 1'b1);
    count_clear = 1'b0;
    chk("clrwin_match", 32'(match2), 1);
    chk("clrwin_count2", 32'(count2), 0);
    chk("clrwin_count8", 32'(count8), 0);

    // Reload mid-pattern discards the partial 110.
    do_load(8'b1101, 4'd4, 1'b1);
    run("pre", 3, 16'b110, 16'b000);
    do_load(8'b101, 4'd3, 1'b1);
    run("mid", 3, 16'b101, 16'b001);
    chk("mid_count", 32'(count8), 1);

    // Zero length disables detection.
    do_load(8'b0, 4'd0, 1'b1);
    run("len0", 6, 16'b110100, 16'b000000);
    chk("len0_armed", 32'(armed8), 0);

    // Over-long length clamps to 8.
    do_load(8'b10110011, 4'd12, 1'b1);
    run("clmpa", 6, 16'b101100, 16'b000000);
    chk("clmp_armed6", 32'(armed8), 0);
    run("clmpb", 1, 16'b1, 16'b0);
    chk("clmp_armed7", 32'(armed8), 1);
    run("clmpc", 1, 16'b1, 16'b1);
    chk("clmp_count", 32'(count8), 2);

    // Async reset mid-stream, then fresh search with default pattern.
    do_load(8'b1101, 4'd4, 1'b1);
    run("ar", 3, 16'b110, 16'b000);
    chk("ar_armed_pre", 32'(armed8), 1);
    #2 n_rst = 1'b0;
    #1;
    chk("ar_armed", 32'(armed8), 0);
    chk("ar_match", 32'(match8), 0);
    chk("ar_count", 32'(count8), 0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    run("post", 4, 16'b1101, 16'b0001);
    chk("post_count", 32'(count8), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
